avl_arbiter: RTL

//  Two-master to one-slave request arbiter sitting directly upstream of the Avalon bridge.

---
 rtl/avl_arbiter_if.sv | 14 +
 rtl/avl_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/avl_arbiter_if.sv
// Request/response channel shared by the two core ports and the bridge port.
// Valid/ready: valid is a one-cycle request pulse, ready a one-cycle completion pulse carrying rdata.
interface avl_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/avl_arbiter.sv
// Two-master (imem/dmem) to one-slave request arbiter with one pending slot per master,
// a single outstanding downstream request, and same-cycle response routing.
module avl_arbiter #(
    parameter bit FAIR = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    avl_arbiter_if.slave   imem,
    avl_arbiter_if.slave   dmem,
    avl_arbiter_if.master  avl,
    output logic [1:0]     state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: dmem was issued most recently
    logic   ip_vld_q, ip_vld_d, dp_vld_q, dp_vld_d;
    req_t   ip_q, ip_d, dp_q, dp_d;
    logic   av_vld_q, av_vld_d;
    req_t   av_q, av_d;

    logic   i_done, d_done, arb_en;
    logic   i_acc, d_acc, i_cand, d_cand, pick_d;
    req_t   i_bus, d_bus, i_sel, d_sel;

    assign i_done = (state_q == BUSY_I) && avl.ready;
    assign d_done = (state_q == BUSY_D) && avl.ready;
    assign arb_en = (state_q == IDLE) || i_done || d_done;

    // A master whose slot is full or whose request is still in flight has its new pulse dropped.
    assign i_acc = imem.valid && !ip_vld_q && !((state_q == BUSY_I) && !avl.ready);
    assign d_acc = dmem.valid && !dp_vld_q && !((state_q == BUSY_D) && !avl.ready);

    assign i_bus  = '{instr: imem.instr, addr: imem.addr, wdata: imem.wdata, wstrb: imem.wstrb};
    assign d_bus  = '{instr: dmem.instr, addr: dmem.addr, wdata: dmem.wdata, wstrb: dmem.wstrb};
    assign i_cand = ip_vld_q || i_acc;
    assign d_cand = dp_vld_q || d_acc;
    assign i_sel  = ip_vld_q ? ip_q : i_bus;
    assign d_sel  = dp_vld_q ? dp_q : d_bus;
    assign pick_d = (i_cand && d_cand) ? (FAIR ? !last_d_q : 1'b1) : d_cand;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        ip_vld_d = ip_vld_q;
        ip_d     = ip_q;
        dp_vld_d = dp_vld_q;
        dp_d     = dp_q;
        av_vld_d = 1'b0;
        av_d     = av_q;

        if (i_done || d_done) state_d = IDLE;

        if (i_acc) begin
            ip_vld_d = 1'b1;
            ip_d     = i_bus;
        end
        if (d_acc) begin
            dp_vld_d = 1'b1;
            dp_d     = d_bus;
        end

        // Arbitration also runs on the completion cycle so back-to-back issues have no bubble.
        if (arb_en && (i_cand || d_cand)) begin
            av_vld_d = 1'b1;
            if (pick_d) begin
                av_d     = d_sel;
                dp_vld_d = 1'b0;
                last_d_d = 1'b1;
                state_d  = BUSY_D;
            end else begin
                av_d     = i_sel;
                ip_vld_d = 1'b0;
                last_d_d = 1'b0;
                state_d  = BUSY_I;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            ip_vld_q <= 1'b0;
            ip_q     <= '0;
            dp_vld_q <= 1'b0;
            dp_q     <= '0;
            av_vld_q <= 1'b0;
            av_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            ip_vld_q <= ip_vld_d;
            ip_q     <= ip_d;
            dp_vld_q <= dp_vld_d;
            dp_q     <= dp_d;
            av_vld_q <= av_vld_d;
            av_q     <= av_d;
        end
    end

    assign avl.valid = av_vld_q;
    assign avl.instr = av_q.instr;
    assign avl.addr  = av_q.addr;
    assign avl.wdata = av_q.wdata;
    assign avl.wstrb = av_q.wstrb;

    assign imem.ready = i_done;
    assign imem.rdata = i_done ? avl.rdata : '0;
    assign dmem.ready = d_done;
    assign dmem.rdata = d_done ? avl.rdata : '0;

    assign state_o = state_q;
endmodule
